// File: rtl/lsu_pkg.sv
// Shared Buceros definitions for the memory-access stage: funct3 codes,
// exception causes, LSU state encoding and alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LD   = 2'b01;
  localparam logic [1:0] CAUSE_ST   = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  typedef enum logic {S_IDLE, S_BUSY} lsu_state_e;

  // Illegal encodings fold into "misaligned" so one path handles both.
  function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = off[0];
      F3_LW:         ld_bad = (off != 2'b00);
      default:       ld_bad = 1'b1;
    endcase
  endfunction

  function automatic logic st_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   st_bad = 1'b0;
      F3_SH:   st_bad = off[0];
      F3_SW:   st_bad = (off != 2'b00);
      default: st_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/strobes and load lane select/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b0000;
    case (st_f3_i)
      F3_SB: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_off_i;
      end
      F3_SH: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << {st_off_i[1], 1'b0};
      end
      F3_SW:   st_wstrb_o = 4'b1111;
      default: st_wstrb_o = 4'b0000;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_b = rdata_i[7:0];
      2'd1:    ld_b = rdata_i[15:8];
      2'd2:    ld_b = rdata_i[23:16];
      default: ld_b = rdata_i[31:24];
    endcase
    ld_h = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_f3_i)
      F3_LB:   ld_data_o = {{24{ld_b[7]}}, ld_b};
      F3_LBU:  ld_data_o = {24'b0, ld_b};
      F3_LH:   ld_data_o = {{16{ld_h[15]}}, ld_h};
      F3_LHU:  ld_data_o = {16'b0, ld_h};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Buceros memory-access stage: one req/ack bus transaction per load/store,
// stalls upstream while outstanding, registered writeback and exceptions.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rmem_en_i,
  input  logic              wmem_en_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [2:0]        funct3_i,
  input  logic              wreg_en_i,
  input  logic [4:0]        wreg_addr_i,
  input  logic [DATA_W-1:0] wreg_data_i,
  output logic              stall_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [3:0]        dbus_wstrb_o,
  input  logic              dbus_ack_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              wb_wreg_en_o,
  output logic [4:0]        wb_wreg_addr_o,
  output logic [DATA_W-1:0] wb_wreg_data_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              rd_en_q;
  logic [4:0]        rd_addr_q;
  logic              wb_en_q;
  logic [4:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              exc_q;
  logic [1:0]        cause_q;

  logic              mem_op, bad_op;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [3:0]        st_wstrb;

  assign mem_op = rmem_en_i | wmem_en_i;
  assign bad_op = (rmem_en_i & wmem_en_i)
                | (rmem_en_i & ld_bad(funct3_i, mem_addr_i[1:0]))
                | (wmem_en_i & st_bad(funct3_i, mem_addr_i[1:0]));

  lsu_align u_align (
    .st_f3_i    (funct3_i),
    .st_off_i   (mem_addr_i[1:0]),
    .st_data_i  (wreg_data_i),
    .st_wdata_o (st_wdata),
    .st_wstrb_o (st_wstrb),
    .ld_f3_i    (f3_q),
    .ld_off_i   (off_q),
    .rdata_i    (dbus_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    stall_o = 1'b0;
    if (state_q == S_BUSY) stall_o = ~dbus_ack_i;
    else                   stall_o = mem_op & ~bad_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      exc_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      wb_en_q <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      case (state_q)
        S_IDLE: begin
          if (mem_op && bad_op) begin
            exc_q   <= 1'b1;
            cause_q <= wmem_en_i ? CAUSE_ST : CAUSE_LD;
          end else if (mem_op) begin
            state_q   <= S_BUSY;
            cnt_q     <= '0;
            req_q     <= 1'b1;
            we_q      <= wmem_en_i;
            addr_q    <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            wdata_q   <= st_wdata;
            wstrb_q   <= wmem_en_i ? st_wstrb : 4'b0000;
            f3_q      <= funct3_i;
            off_q     <= mem_addr_i[1:0];
            rd_en_q   <= wreg_en_i & rmem_en_i;
            rd_addr_q <= wreg_addr_i;
          end else begin
            wb_en_q   <= wreg_en_i;
            wb_addr_q <= wreg_addr_i;
            wb_data_q <= wreg_data_i;
          end
        end
        S_BUSY: begin
          // Ack takes priority over an expiring timeout in the same cycle.
          if (dbus_ack_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            if (!we_q) begin
              wb_en_q   <= rd_en_q;
              wb_addr_q <= rd_addr_q;
              wb_data_q <= ld_data;
            end
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            exc_q   <= 1'b1;
            cause_q <= CAUSE_TMO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbus_req_o     = req_q;
  assign dbus_we_o      = we_q;
  assign dbus_addr_o    = addr_q;
  assign dbus_wdata_o   = wdata_q;
  assign dbus_wstrb_o   = wstrb_q;
  assign wb_wreg_en_o   = wb_en_q;
  assign wb_wreg_addr_o = wb_addr_q;
  assign wb_wreg_data_o = wb_data_q;
  assign exc_o          = exc_q;
  assign exc_cause_o    = cause_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: transaction-level model checked every cycle plus
// literal expectations for the key scenarios.
module tb_lsu;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        rmem, wmem, wen, ack;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  f3;
  logic [4:0]  waddr;
  logic        stall, req, we, wb_en, exc;
  logic [31:0] baddr, bwdata, wb_data;
  logic [3:0]  wstrb;
  logic [4:0]  wb_addr;
  logic [1:0]  cause;

  int checks = 0, errors = 0;

  lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rmem_en_i(rmem), .wmem_en_i(wmem), .mem_addr_i(addr), .funct3_i(f3),
    .wreg_en_i(wen), .wreg_addr_i(waddr), .wreg_data_i(wdata),
    .stall_o(stall), .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(baddr),
    .dbus_wdata_o(bwdata), .dbus_wstrb_o(wstrb), .dbus_ack_i(ack),
    .dbus_rdata_i(rdata), .wb_wreg_en_o(wb_en), .wb_wreg_addr_o(wb_addr),
    .wb_wreg_data_o(wb_data), .exc_o(exc), .exc_cause_o(cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- specification-level helpers ----
  function automatic bit ld_ok(input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit st_ok(input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit legal(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
    if (r && w) return 1'b0;
    return r ? ld_ok(f, a) : st_ok(f, a);
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    case (f)
      3'd0:    return ((v & 32'hFF) >= 32'd128) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd4:    return v & 32'hFF;
      3'd1:    return ((v & 32'hFFFF) >= 32'h8000) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd5:    return v & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] st_word(input logic [2:0] f, input logic [31:0] d);
    case (f)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = (f == 3'd0) ? 1 : (f == 3'd1) ? 3 : 15;
    return 4'(sz << (a % 4));
  endfunction

  // ---- behavioural model: one outstanding transaction at a time ----
  bit          started = 0;
  bit          m_busy = 0;
  int          m_cnt = 0;
  logic        m_load = 0, m_wen = 0;
  logic [2:0]  m_f3 = 0;
  logic [31:0] m_addr = 0;
  logic [4:0]  m_waddr = 0;
  logic        e_req = 0, e_we = 0, e_wb_en = 0, e_exc = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wb_data = 0;
  logic [3:0]  e_wstrb = 0;
  logic [4:0]  e_wb_addr = 0;
  logic [1:0]  e_cause = 0;

  always @(posedge clk) begin
    started = 1;
    e_exc = 0;
    e_cause = 0;
    e_wb_en = 0;
    if (rst) begin
      m_busy = 0; m_cnt = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_wstrb = 0; e_wb_addr = 0; e_wb_data = 0;
    end else if (!m_busy) begin
      if ((rmem || wmem) && !legal(rmem, wmem, f3, addr)) begin
        e_exc = 1;
        e_cause = wmem ? 2'b10 : 2'b01;
      end else if (rmem || wmem) begin
        m_busy = 1; m_cnt = 0;
        m_load = rmem; m_f3 = f3; m_addr = addr; m_wen = wen; m_waddr = waddr;
        e_req = 1; e_we = wmem;
        e_addr = addr & 32'hFFFF_FFFC;
        e_wdata = st_word(f3, wdata);
        e_wstrb = wmem ? st_strb(f3, addr) : 4'd0;
      end else begin
        e_wb_en = wen; e_wb_addr = waddr; e_wb_data = wdata;
      end
    end else if (ack) begin
      m_busy = 0; e_req = 0;
      if (m_load) begin
        e_wb_en = m_wen; e_wb_addr = m_waddr; e_wb_data = ext(m_f3, m_addr, rdata);
      end
    end else begin
      m_cnt++;
      if (m_cnt == TMO) begin
        m_busy = 0; e_req = 0; e_exc = 1; e_cause = 2'b11;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    if (started) begin
      exp_stall = m_busy ? !ack : ((rmem || wmem) && legal(rmem, wmem, f3, addr));
      chk("stall", stall, exp_stall);
      chk("req", req, e_req);
      chk("exc", exc, e_exc);
      chk("wb_en", wb_en, e_wb_en);
      if (e_req) begin
        chk("bus_we", we, e_we);
        chk("bus_addr", baddr, e_addr);
        chk("bus_wdata", bwdata, e_wdata);
        chk("bus_wstrb", wstrb, e_wstrb);
      end
      if (e_exc) chk("exc_cause", cause, e_cause);
      if (e_wb_en) begin
        chk("wb_addr", wb_addr, e_wb_addr);
        chk("wb_data", wb_data, e_wb_data);
      end
    end
  end

  // ---- stimulus ----
  logic        cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          stalls, reqcnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rmem = 0; wmem = 0; wen = 0; f3 = 0; addr = 0; wdata = 0; waddr = 0;
  endtask

  task automatic do_mem(input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa,
                        input int waits, input logic [31:0] rd, output int n_stall);
    rmem = r; wmem = w; f3 = f; addr = a; wdata = d; wen = r; waddr = wa;
    n_stall = 0;
    #1 if (stall) n_stall++;
    step();
    cap_req = req; cap_we = we; cap_addr = baddr; cap_wdata = bwdata; cap_wstrb = wstrb;
    for (int i = 0; i < waits; i++) begin
      #1 if (stall) n_stall++;
      step();
    end
    ack = 1; rdata = rd;
    #1 if (stall) n_stall++;
    step();
    ack = 0;
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; ack = 0; rdata = 0;
    clr();
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_addr", baddr, 0);
    chk("rst_exc", exc, 0);
    chk("rst_wb_en", wb_en, 0);
    rst = 0;
    step();

    // ALU passthrough
    wen = 1; waddr = 5; wdata = 32'h1234;
    #1 chk("add_stall", stall, 0);
    step();
    chk("add_wb_en", wb_en, 1);
    chk("add_wb_addr", wb_addr, 5);
    chk("add_wb_data", wb_data, 32'h1234);
    clr();
    step();

    // LB / LBU from the top byte lane
    do_mem(1, 0, 3'd0, 32'h1003, 0, 5'd7, 3, 32'h80FF_0000, stalls);
    chk("lb_stalls", stalls, 4);
    chk("lb_wb_en", wb_en, 1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    step();
    do_mem(1, 0, 3'd4, 32'h1003, 0, 5'd7, 3, 32'h80FF_0000, stalls);
    chk("lbu_data", wb_data, 32'h0000_0080);

    // LH / LHU upper half
    do_mem(1, 0, 3'd1, 32'h6002, 0, 5'd8, 0, 32'h8001_0000, stalls);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    do_mem(1, 0, 3'd5, 32'h6002, 0, 5'd8, 1, 32'h8001_0000, stalls);
    chk("lhu_data", wb_data, 32'h0000_8001);

    // SH upper half
    do_mem(0, 1, 3'd1, 32'h2002, 32'h0000_BEEF, 5'd0, 1, 0, stalls);
    chk("sh_req", cap_req, 1);
    chk("sh_we", cap_we, 1);
    chk("sh_addr", cap_addr, 32'h2000);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_wb_en", wb_en, 0);

    // SB lane 1
    do_mem(0, 1, 3'd0, 32'h7001, 32'h0000_00AB, 5'd0, 0, 0, stalls);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", cap_wstrb, 4'b0010);

    // Misaligned LW
    rmem = 1; f3 = 3'd2; addr = 32'h3001; wen = 1; waddr = 3;
    #1 chk("mis_stall", stall, 0);
    step();
    chk("mis_req", req, 0);
    chk("mis_exc", exc, 1);
    chk("mis_cause", cause, 2'b01);
    chk("mis_wb_en", wb_en, 0);
    clr();
    step();
    chk("mis_pulse", exc, 0);

    // Both enables set -> store cause; illegal store funct3 -> store cause
    rmem = 1; wmem = 1; f3 = 3'd2; addr = 32'h0;
    step();
    chk("both_cause", cause, 2'b10);
    rmem = 0; f3 = 3'd3;
    step();
    chk("ilst_cause", cause, 2'b10);
    rmem = 1; wmem = 0; f3 = 3'd6;
    step();
    chk("illd_cause", cause, 2'b01);
    clr();
    step();

    // SW with no ack -> timeout
    wmem = 1; f3 = 3'd2; addr = 32'h4000; wdata = 32'hCAFE_F00D;
    step();
    reqcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!req) break;
      reqcnt++;
      step();
    end
    chk("tmo_req_cycles", reqcnt, TMO);
    chk("tmo_exc", exc, 1);
    chk("tmo_cause", cause, 2'b11);
    clr();
    #1 chk("tmo_stall", stall, 0);
    ack = 1; rdata = 32'hDEAD_BEEF;
    step();
    chk("stray_req", req, 0);
    chk("stray_wb_en", wb_en, 0);
    chk("stray_exc", exc, 0);
    ack = 0;
    step();

    // Reset in the second BUSY cycle, then a clean LW
    rmem = 1; f3 = 3'd2; addr = 32'h5000; wen = 1; waddr = 9;
    step();
    step();
    rst = 1;
    step();
    chk("mrst_req", req, 0);
    chk("mrst_exc", exc, 0);
    chk("mrst_wb_en", wb_en, 0);
    rst = 0;
    clr();
    step();
    do_mem(1, 0, 3'd2, 32'h5004, 0, 5'd10, 0, 32'h1234_5678, stalls);
    chk("lw_stalls", stalls, 1);
    chk("lw_wb_en", wb_en, 1);
    chk("lw_wb_addr", wb_addr, 10);
    chk("lw_data", wb_data, 32'h1234_5678);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access stage of the Buceros pipeline; the consuming end of the execute stage's memory interface.
- Takes the execute stage's mem_addr, rmem_en, wmem_en, funct3, store data (carried on wreg_data) and writeback fields.
- Runs one data-bus transaction per load/store using a req/ack handshake, with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline while a transaction is outstanding and presents registered results to writeback.

Parameters:
ADDR_W, 32, width of mem_addr_i and dbus_addr_o
DATA_W, 32, register and bus data width; fixed at 32, the byte-lane logic assumes 4 lanes
TIMEOUT, 255, cycles in BUSY without ack before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rmem_en_i  in  1  load request from execute stage
wmem_en_i  in  1  store request from execute stage
mem_addr_i  in  ADDR_W  byte address
funct3_i  in  3  access size/sign (RV32I load/store encoding)
wreg_en_i  in  1  writeback enable
wreg_addr_i  in  5  writeback register
wreg_data_i  in  DATA_W  ALU result, or store data when wmem_en_i
stall_o  out  1  hold upstream stages (combinational)
dbus_req_o  out  1  bus request (registered)
dbus_we_o  out  1  1 = write
dbus_addr_o  out  ADDR_W  word-aligned address, [1:0]=0
dbus_wdata_o  out  DATA_W  lane-replicated store data
dbus_wstrb_o  out  4  byte strobes; 0 for reads
dbus_ack_i  in  1  transaction complete; rdata valid in the same cycle
dbus_rdata_i  in  DATA_W  read word
wb_wreg_en_o  out  1  registered to writeback
wb_wreg_addr_o  out  5  registered
wb_wreg_data_o  out  DATA_W  registered
exc_o  out  1  one-cycle exception pulse
exc_cause_o  out  2  01 load misaligned/illegal, 10 store misaligned/illegal, 11 bus timeout

Behaviour:
- Single clock clk; rst is synchronous and active-high.
- Reset: state IDLE, timeout counter 0, all outputs 0, dbus_addr_o = 0.
- Alignment check:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Illegal load funct3 (011, 110, 111), illegal store funct3 (≥011), and rmem_en_i & wmem_en_i both set are treated as misaligned.
  - On misalignment: no bus access, exception registered next cycle with cause 01 (load) or 10 (store, including the both-set case), wb_wreg_en_o=0, no stall.
- IDLE:
  - Non-memory op: next edge registers wb_* = inputs; latency 1; exc_o=0.
  - Aligned load/store: stall_o=1 combinationally. Next edge enters BUSY with dbus_req_o=1, we, addr, wdata and wstrb driven from registers. wb_wreg_en_o=0 that cycle (bubble).
- BUSY:
  - dbus_req_o and all bus fields held constant until ack.
  - stall_o = ~dbus_ack_i. Upstream holds inputs stable while stall_o=1.
- Ack in BUSY: next edge returns to IDLE, clears dbus_req_o, and registers writeback.
  - Load: wb_wreg_data_o = extended lane data, wb_wreg_en_o = wreg_en_i.
  - Store: wb_wreg_en_o = 0.
  - Load-to-writeback latency = ack cycle + 1.
- Load extraction by addr[1:0]:
  - LB/LBU select byte lane addr[1:0].
  - LH/LHU select half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Store lanes:
  - SB: wdata = byte replicated ×4, wstrb = 0001 << addr[1:0].
  - SH: wdata = half replicated ×2, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wstrb = 1111.
- Timeout: counter increments each BUSY cycle without ack and clears on leaving BUSY. If TIMEOUT≠0 and the count reaches TIMEOUT:
  - Abort to IDLE and drop dbus_req_o.
  - exc_o=1, exc_cause_o=11, wb_wreg_en_o=0, stall released.
- Ack in the same cycle as timeout: ack wins, no exception.
- Ack while IDLE (stray or late): ignored.
- Reset mid-transaction: request drops at the reset edge, no writeback, no exception.
- Back-to-back memory ops: the next op's request issues no earlier than the cycle after the previous ack (minimum 2 cycles between requests).

Decomposition:
- Shared Buceros header:
  - funct3 load/store codes (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - exception cause codes
  - LSU state encoding (IDLE, BUSY)
- Sub-module lsu_align, combinational: store lane replication/strobe generation and load lane selection/extension. The FSM, counter and registers stay in lsu.

Test Plan:
- ADD passthrough: wreg_en=1, addr=x5, data=0x1234 → next cycle wb_wreg_en=1, wb_wreg_addr=5, wb_wreg_data=0x1234, stall_o=0.
- LB addr=0x1003, ack after 3 BUSY cycles with rdata=0x80FF_0000 → stall_o high 4 cycles, wb_wreg_data=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH addr=0x2002, data=0x0000_BEEF → dbus_we=1, dbus_addr=0x2000, wdata=0xBEEF_BEEF, wstrb=1100; after ack wb_wreg_en=0.
- LW addr=0x3001 → no dbus_req_o, exc_o=1, cause=01 next cycle, stall_o=0.
- TIMEOUT=4, SW with no ack → req high 4 cycles, then exc_o=1, cause=11, req=0. A later stray ack is ignored.
- rst asserted in the 2nd BUSY cycle → req=0 after the edge, no exc, no writeback. A following LW with immediate ack completes normally.
